gmii_rx_frame_parser: RTL
=========================

Name: gmii_rx_frame_parser

Overview:
- Receive-side counterpart of the NIC's GMII transmit path.
- Runs in the PHY receive clock domain and monitors GMII RXD/RX_DV/RX_ER.
- Strips preamble and SFD, delimits each frame with head/tail flags and emits a byte stream with a per-frame error verdict.
- Downstream, an async FIFO moves this stream into the core clock domain, so this block contains no CDC logic.

Parameters:
- MIN_PREAMBLE, 1, minimum number of 0x55 bytes before the SFD for the frame to be accepted.
- MIN_FRAME_LEN, 64, minimum post-SFD length in bytes (FCS included).
- MAX_FRAME_LEN, 1522, maximum post-SFD length in bytes (FCS included, VLAN-tagged).

Ports:
- i_clk  in  1  GMII RX clock (125 MHz).
- i_rst  in  1  Synchronous, active-high reset.
- iv_gmii_rxd  in  8  GMII receive data.
- i_gmii_rx_dv  in  1  GMII data valid.
- i_gmii_rx_er  in  1  GMII receive error.
- ov_pkt_data  out  8  Frame byte (post-SFD).
- o_pkt_data_wr  out  1  Byte valid strobe.
- o_pkt_head  out  1  Marks the first byte of the frame.
- o_pkt_tail  out  1  Marks the last byte of the frame.
- o_pkt_err  out  1  Frame verdict; valid only with o_pkt_tail.
- o_frame_ok_pulse  out  1  One-cycle pulse per good frame.
- o_frame_err_pulse  out  1  One-cycle pulse per bad frame.
- o_preamble_err_pulse  out  1  One-cycle pulse per aborted preamble.

Behaviour:
- Reset: all outputs are 0, counters are cleared, and the state is DROP_S. After reset the block waits for rx_dv=0 before it accepts a frame, so it never syncs mid-frame.
- States: IDLE_S, PREAMBLE_S, DATA_S, DROP_S.
- IDLE_S:
  - rx_dv=1 and rxd=0x55: go to PREAMBLE_S with pre_cnt=1.
  - rx_dv=1 and any other byte: go to DROP_S and pulse o_preamble_err_pulse.
- PREAMBLE_S:
  - rxd=0x55: pre_cnt increments, saturating at 7.
  - rxd=0xD5 and pre_cnt>=MIN_PREAMBLE: go to DATA_S with len_cnt=0, err_seen=0, first=1.
  - rxd=0xD5 with too short a preamble, or any other byte: go to DROP_S and pulse o_preamble_err_pulse.
  - rx_dv=0: go to IDLE_S and pulse o_preamble_err_pulse.
  - rx_er=1: treated as a preamble error and handled the same way.
- DATA_S, on each rx_dv=1 cycle:
  - The incoming byte is captured into a one-byte holding register (hold_vld=1).
  - If hold_vld was already 1, the previously held byte is emitted with o_pkt_data_wr=1 and o_pkt_head=first, and first is then cleared.
  - len_cnt increments, 11 bits wide, saturating at 2047.
  - rx_er=1 sets err_seen.
- DATA_S, on rx_dv=0:
  - The held byte is emitted with o_pkt_tail=1.
  - o_pkt_err = err_seen | (len_cnt<MIN_FRAME_LEN) | (len_cnt>MAX_FRAME_LEN).
  - Exactly one of o_frame_ok_pulse / o_frame_err_pulse fires in the same cycle.
  - State returns to IDLE_S.
- Single-byte frame: head and tail are asserted on the same beat; err=1 because the frame is a runt.
- Empty frame (SFD followed immediately by rx_dv=0): nothing is emitted on the data path, o_frame_err_pulse=1, state goes to IDLE_S.
- Oversize frames: bytes keep streaming, len_cnt saturates, and the verdict is err=1. The block never truncates; dropping the frame is a downstream decision.
- DROP_S: waits for rx_dv=0, then goes to IDLE_S. It emits nothing and raises no further pulses.
- Latency: rxd sampled in cycle N appears on ov_pkt_data in cycle N+2. The data path is registered.
- Back-to-back frames: a single rx_dv=0 cycle between frames is sufficient. The tail emission and the IDLE_S evaluation of the next byte happen without loss.
- Reset asserted mid-frame: outputs clear in the next cycle. No tail or pulse is emitted for the interrupted frame, and the block resyncs via DROP_S.
- Outputs are registered. Pulses are exactly one cycle wide.

Decomposition:
- Shared package gmii_pkg:
  - GMII_PREAMBLE=8'h55 and GMII_SFD=8'hD5.
  - The 2-bit state encoding.
  - Default length constants 64 and 1522.
- Sub-module gmii_rx_byte_delay: the hold register, emission, and head/tail flag generation, driven by the FSM's capture/flush strobes.
- The FSM and length/error checking stay in the top level.

Test Plan:
- Preamble 7×0x55 + 0xD5 + 64 bytes 0x00..0x3F, followed by rx_dv=0 -> 64 writes; head on 0x00; tail on 0x3F; err=0; one ok pulse; first byte appears 2 cycles after sampling.
- Valid preamble + 60-byte frame -> 60 writes; tail with err=1; one err pulse. Also: SFD followed immediately by rx_dv=0 -> no writes and one err pulse.
- 64-byte frame with rx_er=1 on byte 10 -> all 64 bytes emitted; tail err=1. Also: a 1600-byte frame -> 1600 writes and tail err=1.
- rx_dv=1 with first byte 0xAA, frame then continues 70 bytes -> one preamble_err pulse; zero writes; the next valid frame is accepted.
- Two 64-byte frames separated by 1 idle cycle -> 128 writes; two head and two tail flags; two ok pulses.
- Reset asserted at byte 30 of a frame while rx_dv stays high -> no tail or pulse; outputs are 0; remaining bytes are ignored; the next frame after rx_dv=0 is accepted.

Source files
------------

// File: rtl/gmii_pkg.sv
// Shared constants for the GMII receive path.
//   - GMII_PREAMBLE / GMII_SFD : on-wire preamble and start-of-frame bytes
//   - IDLE_S .. DROP_S         : 2-bit receive FSM encoding
//   - GMII_*_FRAME_LEN         : default post-SFD length limits (FCS included)
package gmii_pkg;

   typedef logic [7:0] gmii_byte_t;
   typedef logic [1:0] rx_state_t;

   localparam gmii_byte_t GMII_PREAMBLE = 8'h55;
   localparam gmii_byte_t GMII_SFD      = 8'hD5;

   localparam rx_state_t IDLE_S     = 2'd0;
   localparam rx_state_t PREAMBLE_S = 2'd1;
   localparam rx_state_t DATA_S     = 2'd2;
   localparam rx_state_t DROP_S     = 2'd3;

   localparam int unsigned GMII_MIN_FRAME_LEN = 64;
   localparam int unsigned GMII_MAX_FRAME_LEN = 1522;

   localparam logic [2:0]  PRE_CNT_MAX = 3'd7;
   localparam logic [10:0] LEN_CNT_MAX = 11'h7FF;

endpackage

// File: rtl/gmii_rx_byte_delay.sv
// One-byte holding stage between the receive FSM and the packet interface.
// A byte is only emitted once the next event (another byte, or end of frame)
// is known, so the tail flag can ride on the last byte itself.
// Ports:
//   i_clk, i_rst  : clock, synchronous active-high reset
//   i_start       : new frame accepted; clears hold, arms the head flag
//   i_capture     : iv_data is a frame byte; emit the previously held byte
//   i_flush       : end of frame; emit held byte with tail and i_err verdict
//   ov_data/o_wr/o_head/o_tail/o_err : registered packet outputs
module gmii_rx_byte_delay
   import gmii_pkg::*;
(
   input  logic       i_clk,
   input  logic       i_rst,
   input  logic       i_start,
   input  logic       i_capture,
   input  logic       i_flush,
   input  logic       i_err,
   input  gmii_byte_t iv_data,
   output gmii_byte_t ov_data,
   output logic       o_wr,
   output logic       o_head,
   output logic       o_tail,
   output logic       o_err
);

   gmii_byte_t hold_q;
   logic       hold_vld_q;
   logic       first_q;

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         hold_q     <= '0;
         hold_vld_q <= 1'b0;
         first_q    <= 1'b0;
         ov_data    <= '0;
         o_wr       <= 1'b0;
         o_head     <= 1'b0;
         o_tail     <= 1'b0;
         o_err      <= 1'b0;
      end else begin
         o_wr   <= 1'b0;
         o_head <= 1'b0;
         o_tail <= 1'b0;
         o_err  <= 1'b0;
         if (i_start) begin
            hold_vld_q <= 1'b0;
            first_q    <= 1'b1;
         end else if (i_capture) begin
            hold_q     <= iv_data;
            hold_vld_q <= 1'b1;
            if (hold_vld_q) begin
               ov_data <= hold_q;
               o_wr    <= 1'b1;
               o_head  <= first_q;
               first_q <= 1'b0;
            end
         end else if (i_flush) begin
            hold_vld_q <= 1'b0;
            // An empty frame has nothing held, so no tail is produced.
            if (hold_vld_q) begin
               ov_data <= hold_q;
               o_wr    <= 1'b1;
               o_head  <= first_q;
               o_tail  <= 1'b1;
               o_err   <= i_err;
               first_q <= 1'b0;
            end
         end
      end
   end

endmodule

// File: rtl/gmii_rx_frame_parser.sv
// GMII receive frame parser (PHY RX clock domain, no CDC inside).
// Strips preamble/SFD, delimits frames with head/tail and gives a per-frame
// verdict based on rx_er and post-SFD length.
// Ports:
//   i_clk, i_rst                       : RX clock, synchronous active-high reset
//   iv_gmii_rxd/i_gmii_rx_dv/i_gmii_rx_er : GMII receive inputs
//   ov_pkt_data/o_pkt_data_wr          : post-SFD byte stream
//   o_pkt_head/o_pkt_tail/o_pkt_err    : frame delimiters and verdict (with tail)
//   o_frame_ok_pulse/o_frame_err_pulse : one pulse per completed frame
//   o_preamble_err_pulse               : one pulse per aborted preamble
module gmii_rx_frame_parser
   import gmii_pkg::*;
#(
   parameter int unsigned MIN_PREAMBLE  = 1,
   parameter int unsigned MIN_FRAME_LEN = GMII_MIN_FRAME_LEN,
   parameter int unsigned MAX_FRAME_LEN = GMII_MAX_FRAME_LEN
) (
   input  logic       i_clk,
   input  logic       i_rst,
   input  logic [7:0] iv_gmii_rxd,
   input  logic       i_gmii_rx_dv,
   input  logic       i_gmii_rx_er,
   output logic [7:0] ov_pkt_data,
   output logic       o_pkt_data_wr,
   output logic       o_pkt_head,
   output logic       o_pkt_tail,
   output logic       o_pkt_err,
   output logic       o_frame_ok_pulse,
   output logic       o_frame_err_pulse,
   output logic       o_preamble_err_pulse
);

   rx_state_t   state_q, state_d;
   logic [2:0]  pre_cnt_q, pre_cnt_d;
   logic [10:0] len_cnt_q, len_cnt_d;
   logic        err_seen_q, err_seen_d;

   logic start, capture, flush, frame_bad;
   logic pre_err_d, frame_ok_d, frame_err_d;

   assign frame_bad = err_seen_q
                    | (32'(len_cnt_q) < MIN_FRAME_LEN)
                    | (32'(len_cnt_q) > MAX_FRAME_LEN);

   always_comb begin
      state_d     = state_q;
      pre_cnt_d   = pre_cnt_q;
      len_cnt_d   = len_cnt_q;
      err_seen_d  = err_seen_q;
      start       = 1'b0;
      capture     = 1'b0;
      flush       = 1'b0;
      pre_err_d   = 1'b0;
      frame_ok_d  = 1'b0;
      frame_err_d = 1'b0;
      case (state_q)
         IDLE_S: begin
            if (i_gmii_rx_dv) begin
               if (iv_gmii_rxd == GMII_PREAMBLE) begin
                  state_d   = PREAMBLE_S;
                  pre_cnt_d = 3'd1;
               end else begin
                  state_d   = DROP_S;
                  pre_err_d = 1'b1;
               end
            end
         end
         PREAMBLE_S: begin
            if (!i_gmii_rx_dv) begin
               state_d   = IDLE_S;
               pre_err_d = 1'b1;
            end else if (i_gmii_rx_er) begin
               state_d   = DROP_S;
               pre_err_d = 1'b1;
            end else if (iv_gmii_rxd == GMII_PREAMBLE) begin
               if (pre_cnt_q != PRE_CNT_MAX) pre_cnt_d = pre_cnt_q + 3'd1;
            end else if ((iv_gmii_rxd == GMII_SFD) && (32'(pre_cnt_q) >= MIN_PREAMBLE)) begin
               state_d    = DATA_S;
               len_cnt_d  = '0;
               err_seen_d = 1'b0;
               start      = 1'b1;
            end else begin
               state_d   = DROP_S;
               pre_err_d = 1'b1;
            end
         end
         DATA_S: begin
            if (i_gmii_rx_dv) begin
               capture = 1'b1;
               if (len_cnt_q != LEN_CNT_MAX) len_cnt_d = len_cnt_q + 11'd1;
               if (i_gmii_rx_er) err_seen_d = 1'b1;
            end else begin
               flush       = 1'b1;
               frame_ok_d  = ~frame_bad;
               frame_err_d = frame_bad;
               state_d     = IDLE_S;
            end
         end
         default: begin // DROP_S
            if (!i_gmii_rx_dv) state_d = IDLE_S;
         end
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         // Start in DROP_S so a reset released mid-frame never syncs on it.
         state_q              <= DROP_S;
         pre_cnt_q            <= '0;
         len_cnt_q            <= '0;
         err_seen_q           <= 1'b0;
         o_frame_ok_pulse     <= 1'b0;
         o_frame_err_pulse    <= 1'b0;
         o_preamble_err_pulse <= 1'b0;
      end else begin
         state_q              <= state_d;
         pre_cnt_q            <= pre_cnt_d;
         len_cnt_q            <= len_cnt_d;
         err_seen_q           <= err_seen_d;
         o_frame_ok_pulse     <= frame_ok_d;
         o_frame_err_pulse    <= frame_err_d;
         o_preamble_err_pulse <= pre_err_d;
      end
   end

   gmii_rx_byte_delay u_byte_delay (
      .i_clk     (i_clk),
      .i_rst     (i_rst),
      .i_start   (start),
      .i_capture (capture),
      .i_flush   (flush),
      .i_err     (frame_bad),
      .iv_data   (iv_gmii_rxd),
      .ov_data   (ov_pkt_data),
      .o_wr      (o_pkt_data_wr),
      .o_head    (o_pkt_head),
      .o_tail    (o_pkt_tail),
      .o_err     (o_pkt_err)
   );

endmodule
